// File: rtl/cam_update_ctrl.sv
// cam_update_ctrl: sequences insert/invalidate requests onto a CAM's single
// update port. Every operation probes the CAM first so a key is never stored
// twice. Insert misses go to the lowest free slot, or to a round-robin victim
// when the table is full.
//
// Handshake: a requester raises *_req with its key and holds both until it
// sees *_ack high. *_ack is a one-cycle pulse. The requester drops *_req on the
// clock edge where it samples *_ack. A *_req still high in the IDLE cycle after
// its ack is taken as a new request.
//
// Optional feature: define CAM_UPDATE_CTRL_FLUSH_EN to add flush_req/flush_ack
// and a FLUSH state that invalidates every slot, one per cycle.
//
// dbg_state exposes the FSM state: 0 IDLE, 1 PROBE, 2 COMMIT, 3 FLUSH.
module cam_update_ctrl #(
   parameter int NUM_ENTRIES = 8,
   parameter int KEY_WIDTH   = 32,
   parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   insert_req,
   input  logic [KEY_WIDTH-1:0]   insert_key,
   output logic                   insert_ack,
   output logic [INDEX_WIDTH-1:0] insert_index,
   output logic                   insert_present,
   input  logic                   inval_req,
   input  logic [KEY_WIDTH-1:0]   inval_key,
   output logic                   inval_ack,
   output logic                   inval_hit,
   output logic [KEY_WIDTH-1:0]   cam_lookup_key,
   input  logic                   cam_lookup_hit,
   input  logic [INDEX_WIDTH-1:0] cam_lookup_index,
   output logic                   cam_update_en,
   output logic [KEY_WIDTH-1:0]   cam_update_key,
   output logic [INDEX_WIDTH-1:0] cam_update_index,
   output logic                   cam_update_valid,
   output logic                   busy,
`ifdef CAM_UPDATE_CTRL_FLUSH_EN
   input  logic                   flush_req,
   output logic                   flush_ack,
`endif
   output logic [1:0]             dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PROBE  = 2'd1,
      S_COMMIT = 2'd2
`ifdef CAM_UPDATE_CTRL_FLUSH_EN
      ,
      S_FLUSH  = 2'd3
`endif
   } state_t;

   localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_ENTRIES - 1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic                   r_op_inval;   // 0 = insert, 1 = invalidate
   logic [KEY_WIDTH-1:0]   r_key;
   logic [INDEX_WIDTH-1:0] r_target;
   logic [NUM_ENTRIES-1:0] r_occ;
   logic [INDEX_WIDTH-1:0] r_victim;
   logic                   r_last_ins;   // last granted request was an insert
`ifdef CAM_UPDATE_CTRL_FLUSH_EN
   logic [INDEX_WIDTH-1:0] r_flush_idx;
   logic                   w_grant_flush;
`endif

   logic                   w_grant_ins;
   logic                   w_grant_inv;
   logic                   w_free_found;
   logic [INDEX_WIDTH-1:0] w_free_idx;
   logic [INDEX_WIDTH-1:0] w_target;

   // Lowest-index free slot. The downward scan leaves the lowest one last.
   always_comb begin
      w_free_found = 1'b0;
      w_free_idx   = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (!r_occ[i]) begin
            w_free_found = 1'b1;
            w_free_idx   = INDEX_WIDTH'(i);
         end
      end
   end

   // Arbitration: a lone request wins; with both pending, the type not granted last wins.
   always_comb begin
      w_grant_ins = 1'b0;
      w_grant_inv = 1'b0;
      if (insert_req && inval_req) begin
         w_grant_ins = !r_last_ins;
         w_grant_inv = r_last_ins;
      end else begin
         w_grant_ins = insert_req;
         w_grant_inv = inval_req;
      end
`ifdef CAM_UPDATE_CTRL_FLUSH_EN
      w_grant_flush = flush_req;
      if (flush_req) begin
         w_grant_ins = 1'b0;
         w_grant_inv = 1'b0;
      end
`endif
   end

   // Write target chosen during PROBE.
   always_comb begin
      w_target = '0;
      if (r_op_inval)        w_target = cam_lookup_index;
      else if (w_free_found) w_target = w_free_idx;
      else                   w_target = r_victim;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state and output decode. All outputs are forced low while reset is
   // asserted, so an operation caught by reset never acks or writes the CAM.
   always_comb begin
      w_state_nxt      = r_state;
      insert_ack       = 1'b0;
      insert_index     = '0;
      insert_present   = 1'b0;
      inval_ack        = 1'b0;
      inval_hit        = 1'b0;
      cam_lookup_key   = '0;
      cam_update_en    = 1'b0;
      cam_update_key   = '0;
      cam_update_index = '0;
      cam_update_valid = 1'b0;
      busy             = (r_state != S_IDLE);
      dbg_state        = r_state;
`ifdef CAM_UPDATE_CTRL_FLUSH_EN
      flush_ack        = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
`ifdef CAM_UPDATE_CTRL_FLUSH_EN
            if (w_grant_flush) w_state_nxt = S_FLUSH;
            else
`endif
            if (w_grant_ins || w_grant_inv) w_state_nxt = S_PROBE;
         end
         S_PROBE: begin
            cam_lookup_key = r_key;
            if (!r_op_inval) begin
               if (cam_lookup_hit) begin
                  insert_ack     = 1'b1;
                  insert_present = 1'b1;
                  insert_index   = cam_lookup_index;
                  w_state_nxt    = S_IDLE;
               end else begin
                  w_state_nxt = S_COMMIT;
               end
            end else begin
               if (cam_lookup_hit) begin
                  w_state_nxt = S_COMMIT;
               end else begin
                  inval_ack   = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_COMMIT: begin
            cam_update_en    = 1'b1;
            cam_update_key   = r_key;
            cam_update_index = r_target;
            cam_update_valid = !r_op_inval;
            if (!r_op_inval) begin
               insert_ack   = 1'b1;
               insert_index = r_target;
            end else begin
               inval_ack = 1'b1;
               inval_hit = 1'b1;
            end
            w_state_nxt = S_IDLE;
         end
`ifdef CAM_UPDATE_CTRL_FLUSH_EN
         S_FLUSH: begin
            cam_update_en    = 1'b1;
            cam_update_index = r_flush_idx;
            if (r_flush_idx == LAST_IDX) begin
               flush_ack   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
      if (!reset_n) begin
         insert_ack       = 1'b0;
         insert_index     = '0;
         insert_present   = 1'b0;
         inval_ack        = 1'b0;
         inval_hit        = 1'b0;
         cam_lookup_key   = '0;
         cam_update_en    = 1'b0;
         cam_update_key   = '0;
         cam_update_index = '0;
         cam_update_valid = 1'b0;
         busy             = 1'b0;
         dbg_state        = S_IDLE;
`ifdef CAM_UPDATE_CTRL_FLUSH_EN
         flush_ack        = 1'b0;
`endif
      end
   end

   // Operation capture, occupancy tracking and victim pointer.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_op_inval <= 1'b0;
         r_key      <= '0;
         r_target   <= '0;
         r_occ      <= '0;
         r_victim   <= '0;
         r_last_ins <= 1'b1;
`ifdef CAM_UPDATE_CTRL_FLUSH_EN
         r_flush_idx <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_ins) begin
                  r_key      <= insert_key;
                  r_op_inval <= 1'b0;
                  r_last_ins <= 1'b1;
               end else if (w_grant_inv) begin
                  r_key      <= inval_key;
                  r_op_inval <= 1'b1;
                  r_last_ins <= 1'b0;
               end
`ifdef CAM_UPDATE_CTRL_FLUSH_EN
               r_flush_idx <= '0;
`endif
            end
            S_PROBE: r_target <= w_target;
            S_COMMIT: begin
               if (!r_op_inval) begin
                  r_occ[r_target] <= 1'b1;
                  // Only an overwrite of a live slot consumes the victim.
                  if (r_occ[r_target]) begin
                     if (r_victim == LAST_IDX) r_victim <= '0;
                     else                      r_victim <= r_victim + 1'b1;
                  end
               end else begin
                  r_occ[r_target] <= 1'b0;
               end
            end
`ifdef CAM_UPDATE_CTRL_FLUSH_EN
            S_FLUSH: begin
               if (r_flush_idx == LAST_IDX) begin
                  r_occ    <= '0;
                  r_victim <= '0;
               end else begin
                  r_flush_idx <= r_flush_idx + 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cam_update_ctrl.sv
// Directed bench for cam_update_ctrl with a small behavioural CAM attached.
module tb_cam_update_ctrl;

   localparam int N  = 8;
   localparam int KW = 32;
   localparam int IW = 3;

   logic          clk;
   logic          reset_n;
   logic          insert_req;
   logic [KW-1:0] insert_key;
   logic          insert_ack;
   logic [IW-1:0] insert_index;
   logic          insert_present;
   logic          inval_req;
   logic [KW-1:0] inval_key;
   logic          inval_ack;
   logic          inval_hit;
   logic [KW-1:0] cam_lookup_key;
   logic          cam_lookup_hit;
   logic [IW-1:0] cam_lookup_index;
   logic          cam_update_en;
   logic [KW-1:0] cam_update_key;
   logic [IW-1:0] cam_update_index;
   logic          cam_update_valid;
   logic          busy;
   logic [1:0]    dbg_state;
`ifdef CAM_UPDATE_CTRL_FLUSH_EN
   logic          flush_req;
   logic          flush_ack;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   cam_update_ctrl #(.NUM_ENTRIES(N), .KEY_WIDTH(KW)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .insert_req       (insert_req),
      .insert_key       (insert_key),
      .insert_ack       (insert_ack),
      .insert_index     (insert_index),
      .insert_present   (insert_present),
      .inval_req        (inval_req),
      .inval_key        (inval_key),
      .inval_ack        (inval_ack),
      .inval_hit        (inval_hit),
      .cam_lookup_key   (cam_lookup_key),
      .cam_lookup_hit   (cam_lookup_hit),
      .cam_lookup_index (cam_lookup_index),
      .cam_update_en    (cam_update_en),
      .cam_update_key   (cam_update_key),
      .cam_update_index (cam_update_index),
      .cam_update_valid (cam_update_valid),
      .busy             (busy),
`ifdef CAM_UPDATE_CTRL_FLUSH_EN
      .flush_req        (flush_req),
      .flush_ack        (flush_ack),
`endif
      .dbg_state        (dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural CAM: combinational lookup, write on update strobe
   logic [KW-1:0] cam_key [N];
   logic          cam_vld [N];

   always_comb begin
      cam_lookup_hit   = 1'b0;
      cam_lookup_index = '0;
      for (int i = 0; i < N; i++) begin
         if (!cam_lookup_hit && cam_vld[i] && cam_key[i] == cam_lookup_key) begin
            cam_lookup_hit   = 1'b1;
            cam_lookup_index = IW'(i);
         end
      end
   end

   always @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < N; i++) begin
            cam_vld[i] <= 1'b0;
            cam_key[i] <= '0;
         end
      end else if (cam_update_en) begin
         cam_key[cam_update_index] <= cam_update_key;
         cam_vld[cam_update_index] <= cam_update_valid;
      end
   end

   // Update-port monitor
   int            upd_total = 0;
   logic [IW-1:0] last_idx  = '0;
   logic          last_vld  = 1'b0;
   logic [KW-1:0] last_key  = '0;

   always @(posedge clk) begin
      if (reset_n && cam_update_en) begin
         upd_total <= upd_total + 1;
         last_idx  <= cam_update_index;
         last_vld  <= cam_update_valid;
         last_key  <= cam_update_key;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Insert driver; called in an IDLE cycle, returns in the IDLE cycle after the ack.
   task automatic do_insert(input logic [KW-1:0] key, input int exp_lat,
                            input logic [IW-1:0] exp_idx, input logic exp_present,
                            input string tag);
      int lat;
      int base;
      bit got;
      base       = upd_total;
      insert_key = key;
      insert_req = 1'b1;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 10) begin
         @(posedge clk); #1;
         lat++;
         if (insert_ack) got = 1'b1;
      end
      check({tag, "_acked"}, 64'(got), 64'd1);
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_index"}, 64'(insert_index), 64'(exp_idx));
      check({tag, "_present"}, 64'(insert_present), 64'(exp_present));
      insert_req = 1'b0;
      @(posedge clk); #1;
      check({tag, "_ack_pulse"}, 64'(insert_ack), 64'd0);
      check({tag, "_writes"}, 64'(upd_total - base), exp_present ? 64'd0 : 64'd1);
      if (!exp_present) begin
         check({tag, "_wr_idx"}, 64'(last_idx), 64'(exp_idx));
         check({tag, "_wr_vld"}, 64'(last_vld), 64'd1);
         check({tag, "_wr_key"}, 64'(last_key), 64'(key));
      end
   endtask

   // Invalidate driver; same phase rules as do_insert.
   task automatic do_inval(input logic [KW-1:0] key, input int exp_lat,
                           input logic exp_hit, input logic [IW-1:0] exp_idx,
                           input string tag);
      int lat;
      int base;
      bit got;
      base      = upd_total;
      inval_key = key;
      inval_req = 1'b1;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 10) begin
         @(posedge clk); #1;
         lat++;
         if (inval_ack) got = 1'b1;
      end
      check({tag, "_acked"}, 64'(got), 64'd1);
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_hit"}, 64'(inval_hit), 64'(exp_hit));
      inval_req = 1'b0;
      @(posedge clk); #1;
      check({tag, "_writes"}, 64'(upd_total - base), exp_hit ? 64'd1 : 64'd0);
      if (exp_hit) begin
         check({tag, "_wr_idx"}, 64'(last_idx), 64'(exp_idx));
         check({tag, "_wr_vld"}, 64'(last_vld), 64'd0);
      end
   endtask

   // Directed sequence
   initial begin
      int            n_ins;
      int            n_inv;
      int            k;
      int            cyc;
      int            base;
      int            lat;
      bit            got;
      logic          seq [4];
      logic [IW-1:0] arb_idx [2];

      reset_n    = 1'b0;
      insert_req = 1'b0;
      insert_key = '0;
      inval_req  = 1'b0;
      inval_key  = '0;
`ifdef CAM_UPDATE_CTRL_FLUSH_EN
      flush_req  = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
      check("rst_ins_ack", 64'(insert_ack), 64'd0);
      check("rst_inv_ack", 64'(inval_ack), 64'd0);
      check("rst_upd_en", 64'(cam_update_en), 64'd0);
      check("rst_lookup_key", 64'(cam_lookup_key), 64'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Fill from empty
      for (int i = 0; i < N; i++)
         do_insert(KW'(32'h100 + i), 2, IW'(i), 1'b0, $sformatf("fill%0d", i));

      // Duplicate key
      do_insert(32'h103, 1, 3'd3, 1'b1, "dup");

      // Replacement when full, free slot preferred over victim
      do_insert(32'h200, 2, 3'd0, 1'b0, "repl0");
      do_insert(32'h201, 2, 3'd1, 1'b0, "repl1");
      do_inval(32'h201, 2, 1'b1, 3'd1, "inv201");
      do_insert(32'h202, 2, 3'd1, 1'b0, "free1");
      do_insert(32'h203, 2, 3'd2, 1'b0, "victim2");

      // Absent key
      do_inval(32'hDEAD, 1, 1'b0, 3'd0, "inv_miss");

      // Arbitration: both requesters held high with fresh keys
      arb_idx[0] = 3'd3;
      arb_idx[1] = 3'd4;
      n_ins = 0;
      n_inv = 0;
      k     = 0;
      cyc   = 0;
      insert_key = 32'h300;
      inval_key  = 32'h104;
      insert_req = 1'b1;
      inval_req  = 1'b1;
      while ((n_ins < 2 || n_inv < 2) && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (insert_ack) begin
            check($sformatf("arb_ins%0d_idx", n_ins), 64'(insert_index), 64'(arb_idx[n_ins]));
            if (k < 4) seq[k] = 1'b0;
            k++;
            n_ins++;
            if (n_ins == 2) insert_req = 1'b0;
            else            insert_key = 32'h301;
         end
         if (inval_ack) begin
            check($sformatf("arb_inv%0d_hit", n_inv), 64'(inval_hit), 64'd1);
            if (k < 4) seq[k] = 1'b1;
            k++;
            n_inv++;
            if (n_inv == 2) inval_req = 1'b0;
            else            inval_key = 32'h105;
         end
      end
      insert_req = 1'b0;
      inval_req  = 1'b0;
      check("arb_count", 64'(k), 64'd4);
      if (k == 4) begin
         check("arb_order0", 64'(seq[0]), 64'd0);
         check("arb_order1", 64'(seq[1]), 64'd1);
         check("arb_order2", 64'(seq[2]), 64'd0);
         check("arb_order3", 64'(seq[3]), 64'd1);
      end
      @(posedge clk); #1;

      // Slot 5 freed by the second invalidate; victim pointer sits at 4
      do_insert(32'h302, 2, 3'd5, 1'b0, "free5");
      do_insert(32'h303, 2, 3'd4, 1'b0, "victim4");

      // Reset during COMMIT
      base       = upd_total;
      insert_key = 32'h400;
      insert_req = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rstmid_in_commit", 64'(dbg_state), 64'd2);
      reset_n = 1'b0;
      #1;
      check("rstmid_no_ack", 64'(insert_ack), 64'd0);
      check("rstmid_no_write", 64'(cam_update_en), 64'd0);
      insert_req = 1'b0;
      @(posedge clk); #1;
      check("rstmid_busy", 64'(busy), 64'd0);
      check("rstmid_writes", 64'(upd_total - base), 64'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
         do_insert(KW'(32'h100 + i), 2, IW'(i), 1'b0, $sformatf("refill%0d", i));
      // Victim pointer restarted at 0
      do_insert(32'h600, 2, 3'd0, 1'b0, "victim_rst");

`ifdef CAM_UPDATE_CTRL_FLUSH_EN
      // Flush with every slot occupied
      base      = upd_total;
      flush_req = 1'b1;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (flush_ack) got = 1'b1;
      end
      check("flush_acked", 64'(got), 64'd1);
      check("flush_lat", 64'(lat), 64'(N));
      check("flush_last_idx", 64'(cam_update_index), 64'(N - 1));
      flush_req = 1'b0;
      @(posedge clk); #1;
      check("flush_writes", 64'(upd_total - base), 64'(N));
      check("flush_wr_idx", 64'(last_idx), 64'(N - 1));
      check("flush_wr_vld", 64'(last_vld), 64'd0);
      check("flush_wr_key", 64'(last_key), 64'd0);
      check("flush_busy", 64'(busy), 64'd0);
      do_insert(32'h500, 2, 3'd0, 1'b0, "post_flush");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
